// File: rtl/shreg_serial_loader.sv
// Parallel-to-serial feeder for a downstream DFF shift chain: takes a word over
// valid/ready, optionally clears the chain, then emits one bit per DIV clocks.
module shreg_serial_loader #(
  parameter int WIDTH         = 4,
  parameter int DIV           = 1,
  parameter int MSB_FIRST     = 1,
  parameter int CLEAR_ON_LOAD = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             SER_D,
  output logic             SER_EN,
  output logic             SR_CLR,
  output logic             BUSY,
  output logic             DONE
);

  localparam int PW = $clog2(DIV + 1);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [CW-1:0]    bit_q;
  logic [WIDTH-1:0] data_q;
  logic             ser_d_q;
  logic             ser_en_q;
  logic             sr_clr_q;
  logic             done_q;
  logic             accept_d;
  logic             tick_d;

  // DONE is flagged on the way back to IDLE; readiness waits until it has gone.
  assign IN_READY = (state_q == S_IDLE) && !done_q;
  assign BUSY     = (state_q != S_IDLE);
  assign accept_d = IN_VALID && IN_READY;
  assign tick_d   = (presc_q == PRESC_LAST);

  assign SER_D  = ser_d_q;
  assign SER_EN = ser_en_q;
  assign SR_CLR = sr_clr_q;
  assign DONE   = done_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      ser_d_q  <= 1'b0;
      ser_en_q <= 1'b0;
      sr_clr_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ser_en_q <= 1'b0;
      sr_clr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            data_q   <= IN_DATA;
            presc_q  <= '0;
            bit_q    <= '0;
            sr_clr_q <= (CLEAR_ON_LOAD != 0);
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Prescaler starts at 0 on accept, so with DIV=1 the first pulse
          // lands one cycle after the clear pulse rather than on top of it.
          if (tick_d) begin
            presc_q  <= '0;
            ser_en_q <= 1'b1;
            if (MSB_FIRST != 0) begin
              ser_d_q <= data_q[WIDTH-1];
              data_q  <= data_q << 1;
            end else begin
              ser_d_q <= data_q[0];
              data_q  <= data_q >> 1;
            end
            if (bit_q == BIT_LAST) begin
              state_q <= S_DONE;
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
